// File: rtl/bus_master_port.sv
// Bus master initiator: takes one local read/write command, arbitrates, then shifts address/data LSB first.
// Optional read-data timeout enabled by defining BUS_MASTER_TIMEOUT_EN.
module bus_master_port #(
  parameter int ADDR_WIDTH     = 12,
  parameter int DATA_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [1:0]            cmd_slave,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_error,
  output logic                  m_request,
  output logic [1:0]            m_slave_sel,
  input  logic                  m_grant,
  output logic                  bus_out,
  output logic                  bus_out_valid,
  output logic                  bus_mode,
  input  logic                  bus_in,
  input  logic                  bus_in_valid
);

  localparam int MAXW = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
  localparam int CW   = $clog2(MAXW) + 1;
  localparam logic [CW-1:0] A_LAST  = CW'(ADDR_WIDTH - 1);
  localparam logic [CW-1:0] D_LAST  = CW'(DATA_WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_ADDR, S_WDATA, S_RDATA, S_DONE
  } state_e;

  state_e                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  write_q, write_d;
  logic [1:0]            slave_q, slave_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rd_shift_q, rd_shift_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  err_q, err_d;
  logic [DATA_WIDTH-1:0] rd_next;

`ifdef BUS_MASTER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);
  logic [TW-1:0] tmo_q, tmo_d;
`else
  // Timeout limit has no effect in this build.
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

  assign rd_next   = {bus_in, rd_shift_q[DATA_WIDTH-1:1]};
  assign rsp_rdata = rsp_rdata_q;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    write_d       = write_q;
    slave_d       = slave_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    rd_shift_d    = rd_shift_q;
    rsp_rdata_d   = rsp_rdata_q;
    err_d         = err_q;
`ifdef BUS_MASTER_TIMEOUT_EN
    tmo_d         = tmo_q;
`endif
    cmd_ready     = 1'b0;
    rsp_valid     = 1'b0;
    rsp_error     = 1'b0;
    m_request     = 1'b0;
    m_slave_sel   = 2'b00;
    bus_out       = 1'b0;
    bus_out_valid = 1'b0;
    bus_mode      = 1'b0;
    case (state_q)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          write_d    = cmd_write;
          slave_d    = cmd_slave;
          addr_d     = cmd_addr;
          wdata_d    = cmd_wdata;
          rd_shift_d = '0;
          cnt_d      = '0;
          err_d      = 1'b0;
`ifdef BUS_MASTER_TIMEOUT_EN
          tmo_d      = '0;
`endif
          state_d    = S_REQ;
        end
      end
      S_REQ: begin
        m_request   = 1'b1;
        m_slave_sel = slave_q;
        if (m_grant) begin
          cnt_d   = '0;
          state_d = S_ADDR;
        end
      end
      S_ADDR, S_WDATA, S_RDATA: begin
        m_request   = 1'b1;
        m_slave_sel = slave_q;
        bus_mode    = write_q;
        // Losing grant aborts at once: nothing is driven or captured this cycle.
        if (!m_grant) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else if (state_q == S_ADDR) begin
          bus_out_valid = 1'b1;
          bus_out       = addr_q[0];
          addr_d        = addr_q >> 1;
          cnt_d         = cnt_q + CNT_ONE;
          if (cnt_q == A_LAST) begin
            cnt_d   = '0;
            state_d = write_q ? S_WDATA : S_RDATA;
          end
        end else if (state_q == S_WDATA) begin
          bus_out_valid = 1'b1;
          bus_out       = wdata_q[0];
          wdata_d       = wdata_q >> 1;
          cnt_d         = cnt_q + CNT_ONE;
          if (cnt_q == D_LAST) begin
            cnt_d   = '0;
            state_d = S_DONE;
          end
        end else if (bus_in_valid) begin
          rd_shift_d = rd_next;
          cnt_d      = cnt_q + CNT_ONE;
`ifdef BUS_MASTER_TIMEOUT_EN
          tmo_d      = '0;
`endif
          if (cnt_q == D_LAST) begin
            cnt_d       = '0;
            rsp_rdata_d = rd_next;
            state_d     = S_DONE;
          end
        end else begin
`ifdef BUS_MASTER_TIMEOUT_EN
          tmo_d = tmo_q + TW'(1);
          if (tmo_q == T_LAST) begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end
`endif
        end
      end
      S_DONE: begin
        rsp_valid = 1'b1;
        rsp_error = err_q;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      write_q     <= 1'b0;
      slave_q     <= 2'b00;
      addr_q      <= '0;
      wdata_q     <= '0;
      rd_shift_q  <= '0;
      rsp_rdata_q <= '0;
      err_q       <= 1'b0;
`ifdef BUS_MASTER_TIMEOUT_EN
      tmo_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      write_q     <= write_d;
      slave_q     <= slave_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rd_shift_q  <= rd_shift_d;
      rsp_rdata_q <= rsp_rdata_d;
      err_q       <= err_d;
`ifdef BUS_MASTER_TIMEOUT_EN
      tmo_q       <= tmo_d;
`endif
    end
  end

endmodule

// File: tb/tb_bus_master_port.sv
// Directed bench for bus_master_port: write/read serialisation, grant wait/loss, reset abort, back-to-back, timeout.
module tb_bus_master_port;
  localparam int AW = 12;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [1:0]    cmd_slave;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid, rsp_error;
  logic [DW-1:0] rsp_rdata;
  logic          m_request, m_grant;
  logic [1:0]    m_slave_sel;
  logic          bus_out, bus_out_valid, bus_mode, bus_in, bus_in_valid;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  always #5 clk = ~clk;

  bus_master_port #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(20)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_slave(cmd_slave), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
    .m_request(m_request), .m_slave_sel(m_slave_sel), .m_grant(m_grant),
    .bus_out(bus_out), .bus_out_valid(bus_out_valid), .bus_mode(bus_mode),
    .bus_in(bus_in), .bus_in_valid(bus_in_valid)
  );

  // Presents one command for a single cycle; returns at the negedge of the REQ cycle.
  task automatic issue_cmd(input logic w, input logic [1:0] s, input logic [AW-1:0] a,
                           input logic [DW-1:0] d);
    @(negedge clk);
    cmd_write = w; cmd_slave = s; cmd_addr = a; cmd_wdata = d; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_slave = 2'b00; cmd_addr = '0;
    cmd_wdata = '0; m_grant = 1'b0; bus_in = 1'b0; bus_in_valid = 1'b0;
    @(negedge clk); @(negedge clk);
    chk_cnt++;
    if ({cmd_ready, rsp_valid, rsp_error, m_request, m_slave_sel, bus_out, bus_out_valid, bus_mode} !== 9'b1_0000_0000)
      $display("FAIL reset_outputs: got %b want 100000000",
               {cmd_ready, rsp_valid, rsp_error, m_request, m_slave_sel, bus_out, bus_out_valid, bus_mode});
    else pass_cnt++;
    chk_cnt++;
    if (rsp_rdata !== 8'h00) $display("FAIL reset_rdata: got %h want 00", rsp_rdata); else pass_cnt++;
    rst = 1'b0;
  endtask

  task automatic test_write();
    logic [19:0] bits;
    int nb, rk;
    logic mode_ok, done_req;
    bits = '0; nb = 0; rk = 0; mode_ok = 1'b1; done_req = 1'b1;
    issue_cmd(1'b1, 2'b10, 12'hA5C, 8'h3C);
    chk_cnt++;
    if ({m_request, m_slave_sel, bus_out_valid, cmd_ready} !== 5'b11000)
      $display("FAIL write_req: got %b want 11000", {m_request, m_slave_sel, bus_out_valid, cmd_ready});
    else pass_cnt++;
    m_grant = 1'b1;
    for (int k = 2; k <= 40; k++) begin
      @(negedge clk);
      if (rsp_valid) begin rk = k; done_req = m_request; break; end
      if (bus_out_valid) begin
        if (nb < 20) bits[nb] = bus_out;
        nb++;
        if (bus_mode !== 1'b1) mode_ok = 1'b0;
      end
    end
    chk_cnt++;
    if (rk !== 22) $display("FAIL write_latency: got %0d want 22", rk); else pass_cnt++;
    chk_cnt++;
    if (nb !== 20) $display("FAIL write_bitcount: got %0d want 20", nb); else pass_cnt++;
    chk_cnt++;
    if (bits[11:0] !== 12'hA5C) $display("FAIL write_addr_bits: got %h want a5c", bits[11:0]); else pass_cnt++;
    chk_cnt++;
    if (bits[19:12] !== 8'h3C) $display("FAIL write_data_bits: got %h want 3c", bits[19:12]); else pass_cnt++;
    chk_cnt++;
    if ({mode_ok, rsp_error, done_req} !== 3'b100)
      $display("FAIL write_mode_err_req: got %b want 100", {mode_ok, rsp_error, done_req});
    else pass_cnt++;
    m_grant = 1'b0;
    @(negedge clk);
    chk_cnt++;
    if ({cmd_ready, rsp_valid} !== 2'b10) $display("FAIL write_idle: got %b want 10", {cmd_ready, rsp_valid});
    else pass_cnt++;
  endtask

  task automatic test_read();
    logic [DW-1:0] rd;
    int nab, idx, ph, rk;
    logic done_req;
    rd = 8'h96; nab = 0; idx = 0; ph = 0; rk = 0; done_req = 1'b1;
    issue_cmd(1'b0, 2'b01, 12'h123, 8'hFF);
    chk_cnt++;
    if (m_slave_sel !== 2'b01) $display("FAIL read_sel: got %b want 01", m_slave_sel); else pass_cnt++;
    m_grant = 1'b1;
    for (int k = 2; k <= 80; k++) begin
      @(negedge clk);
      bus_in_valid = 1'b0;
      if (rsp_valid) begin rk = k; done_req = m_request; break; end
      if (nab < AW) begin
        // Junk read bits during the address phase must be ignored.
        if (bus_out_valid) begin nab++; bus_in_valid = 1'b1; bus_in = 1'b1; end
      end else if (idx < DW) begin
        if (ph == 2) begin bus_in_valid = 1'b1; bus_in = rd[idx]; idx++; ph = 0; end
        else ph++;
      end
    end
    bus_in_valid = 1'b0; m_grant = 1'b0;
    chk_cnt++;
    if (rk !== 38) $display("FAIL read_latency: got %0d want 38", rk); else pass_cnt++;
    chk_cnt++;
    if (rsp_rdata !== 8'h96) $display("FAIL read_data: got %h want 96", rsp_rdata); else pass_cnt++;
    chk_cnt++;
    if ({rsp_error, done_req} !== 2'b00) $display("FAIL read_err_req: got %b want 00", {rsp_error, done_req});
    else pass_cnt++;
  endtask

  task automatic test_grant_wait();
    logic steady;
    logic [19:0] bits;
    int nb, rk;
    steady = 1'b1; bits = '0; nb = 0; rk = 0;
    issue_cmd(1'b1, 2'b11, 12'h001, 8'h81);
    for (int j = 0; j < 10; j++) begin
      if ({m_request, m_slave_sel, bus_out_valid} !== 4'b1110) steady = 1'b0;
      if (j < 9) @(negedge clk);
    end
    chk_cnt++;
    if (steady !== 1'b1) $display("FAIL grant_wait_steady: got %b want 1", steady); else pass_cnt++;
    m_grant = 1'b1;
    for (int k = 11; k <= 50; k++) begin
      @(negedge clk);
      if (rsp_valid) begin rk = k; break; end
      if (bus_out_valid) begin if (nb < 20) bits[nb] = bus_out; nb++; end
    end
    chk_cnt++;
    if (rk !== 31) $display("FAIL grant_wait_latency: got %0d want 31", rk); else pass_cnt++;
    chk_cnt++;
    if ({nb[7:0], bits} !== {8'd20, 8'h81, 12'h001})
      $display("FAIL grant_wait_bits: got %0d/%h want 20/81001", nb, bits);
    else pass_cnt++;
    chk_cnt++;
    if ({rsp_error, rsp_rdata} !== 9'h096)
      $display("FAIL grant_wait_rsp: got err %b rdata %h want 0/96", rsp_error, rsp_rdata);
    else pass_cnt++;
    m_grant = 1'b0;
  endtask

  task automatic test_grant_loss();
    int nb;
    nb = 0;
    issue_cmd(1'b1, 2'b00, 12'hFFF, 8'h00);
    m_grant = 1'b1;
    for (int k = 2; k <= 6; k++) begin
      @(negedge clk);
      if (bus_out_valid) nb++;
    end
    @(negedge clk);
    m_grant = 1'b0;
    #1;
    chk_cnt++;
    if ({nb[3:0], bus_out_valid, m_request} !== 6'b0101_0_1)
      $display("FAIL loss_stop: got bits %0d valid %b req %b want 5/0/1", nb, bus_out_valid, m_request);
    else pass_cnt++;
    @(negedge clk);
    chk_cnt++;
    if ({rsp_valid, rsp_error, m_request} !== 3'b110)
      $display("FAIL loss_rsp: got %b want 110", {rsp_valid, rsp_error, m_request});
    else pass_cnt++;
    @(negedge clk);
    chk_cnt++;
    if ({cmd_ready, rsp_valid} !== 2'b10) $display("FAIL loss_idle: got %b want 10", {cmd_ready, rsp_valid});
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    logic early_rsp;
    early_rsp = 1'b0;
    issue_cmd(1'b1, 2'b10, 12'h5A5, 8'hF0);
    m_grant = 1'b1;
    for (int k = 2; k <= 16; k++) begin
      @(negedge clk);
      if (rsp_valid) early_rsp = 1'b1;
    end
    rst = 1'b1;
    @(negedge clk);
    chk_cnt++;
    if ({early_rsp, cmd_ready, rsp_valid, rsp_error, m_request, m_slave_sel, bus_out, bus_out_valid, bus_mode}
        !== 10'b0_1_0000_0000)
      $display("FAIL reset_mid_outputs: got %b want 0100000000",
               {early_rsp, cmd_ready, rsp_valid, rsp_error, m_request, m_slave_sel, bus_out, bus_out_valid, bus_mode});
    else pass_cnt++;
    chk_cnt++;
    if (rsp_rdata !== 8'h00) $display("FAIL reset_mid_rdata: got %h want 00", rsp_rdata); else pass_cnt++;
    rst = 1'b0; m_grant = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [19:0] bits_a, bits_b;
    int na, nb, r1, r2;
    logic ready_done, ready_idle;
    logic [1:0] sel_b;
    bits_a = '0; bits_b = '0; na = 0; nb = 0; r1 = 0; r2 = 0;
    ready_done = 1'b1; ready_idle = 1'b0; sel_b = 2'b00;
    m_grant = 1'b1;
    @(negedge clk);
    cmd_write = 1'b1; cmd_slave = 2'b01; cmd_addr = 12'h3C5; cmd_wdata = 8'hA7; cmd_valid = 1'b1;
    @(negedge clk);
    // Held valid with new fields while busy: must not disturb the first transaction.
    cmd_slave = 2'b10; cmd_addr = 12'h0F0; cmd_wdata = 8'h5E;
    for (int k = 2; k <= 80; k++) begin
      @(negedge clk);
      if (k == 24) begin cmd_valid = 1'b0; sel_b = m_slave_sel; end
      if (k == 22) ready_done = cmd_ready;
      if (k == 23) ready_idle = cmd_ready;
      if (rsp_valid) begin
        if (r1 == 0) r1 = k;
        else begin r2 = k; break; end
      end
      if (bus_out_valid) begin
        if (k < 22) begin if (na < 20) bits_a[na] = bus_out; na++; end
        else begin if (nb < 20) bits_b[nb] = bus_out; nb++; end
      end
    end
    m_grant = 1'b0;
    chk_cnt++;
    if ({ready_done, ready_idle} !== 2'b01)
      $display("FAIL b2b_ready: got done %b idle %b want 0/1", ready_done, ready_idle);
    else pass_cnt++;
    chk_cnt++;
    if (r1 !== 22 || r2 !== 45) $display("FAIL b2b_latency: got %0d,%0d want 22,45", r1, r2); else pass_cnt++;
    chk_cnt++;
    if (bits_a !== {8'hA7, 12'h3C5}) $display("FAIL b2b_first_bits: got %h want a73c5", bits_a); else pass_cnt++;
    chk_cnt++;
    if (bits_b !== {8'h5E, 12'h0F0}) $display("FAIL b2b_second_bits: got %h want 5e0f0", bits_b); else pass_cnt++;
    chk_cnt++;
    if ({sel_b, rsp_error} !== 3'b100) $display("FAIL b2b_sel_err: got %b want 100", {sel_b, rsp_error});
    else pass_cnt++;
  endtask

  task automatic test_timeout();
    int rk;
    logic still_req;
    rk = 0; still_req = 1'b0;
    issue_cmd(1'b0, 2'b00, 12'h000, 8'h00);
    m_grant = 1'b1;
`ifdef BUS_MASTER_TIMEOUT_EN
    for (int k = 2; k <= 60; k++) begin
      @(negedge clk);
      if (rsp_valid) begin rk = k; still_req = rsp_error; break; end
    end
    chk_cnt++;
    if (rk !== 34 || still_req !== 1'b1)
      $display("FAIL timeout_abort: got cycle %0d err %b want 34/1", rk, still_req);
    else pass_cnt++;
    m_grant = 1'b0;
`else
    for (int k = 2; k <= 114; k++) begin
      @(negedge clk);
      if (rsp_valid) begin rk = k; break; end
      still_req = m_request;
    end
    chk_cnt++;
    if (rk !== 0 || still_req !== 1'b1)
      $display("FAIL timeout_wait: got rsp cycle %0d req %b want 0/1", rk, still_req);
    else pass_cnt++;
    m_grant = 1'b0;
    @(negedge clk);
    chk_cnt++;
    if ({rsp_valid, rsp_error} !== 2'b11) $display("FAIL timeout_release: got %b want 11", {rsp_valid, rsp_error});
    else pass_cnt++;
`endif
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_grant_wait();
    test_grant_loss();
    test_reset_mid();
    test_back_to_back();
    test_timeout();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/bus_master_port.md
Name: bus_master_port

Overview:
- Master-side initiator of the system bus.
- Accepts one local read/write command and requests the bus from the two-master arbiter with a 2-bit slave select.
- After grant, serialises address and write data to the selected slave, or collects serial read data from it.
- Returns a single-cycle response to the local logic. One instance per master; its request/grant pair connects to the arbiter's m1 or m2 ports.

Parameters:
- ADDR_WIDTH, 12, address bits shifted per transaction
- DATA_WIDTH, 8, data bits per transaction
- TIMEOUT_CYCLES, 255, read-data wait limit (used only with the optional feature)

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous, active-high reset
- cmd_valid  input  1  local command present
- cmd_ready  output  1  high only in IDLE; command accepted when cmd_valid && cmd_ready
- cmd_write  input  1  1 = write, 0 = read
- cmd_slave  input  2  target slave select
- cmd_addr  input  ADDR_WIDTH  target address
- cmd_wdata  input  DATA_WIDTH  write data
- rsp_valid  output  1  single-cycle completion pulse
- rsp_rdata  output  DATA_WIDTH  read data; holds value until next read completes
- rsp_error  output  1  valid with rsp_valid; 1 = aborted transaction
- m_request  output  1  bus request to arbiter
- m_slave_sel  output  2  slave select to arbiter
- m_grant  input  1  grant from arbiter
- bus_out  output  1  serial address/write-data bit, LSB first
- bus_out_valid  output  1  bus_out bit valid this cycle
- bus_mode  output  1  1 = write, 0 = read; valid while granted
- bus_in  input  1  serial read-data bit from slave
- bus_in_valid  input  1  bus_in valid this cycle

Behaviour:
- Reset: all outputs 0 except cmd_ready = 1. State = IDLE. Counters and shift registers are cleared.
- Reset mid-transaction: abandons the transaction without issuing rsp_valid; m_request drops on the next cycle.
- IDLE: cmd_ready = 1. On accept, latch write/slave/addr/wdata and go to REQ.
- REQ: m_request = 1 and m_slave_sel = latched slave, both held stable. Wait indefinitely for m_grant. When m_grant = 1 is sampled, go to ADDR.
- ADDR: bus_out_valid = 1 for exactly ADDR_WIDTH consecutive cycles, one address bit per cycle, LSB first. bus_mode = latched cmd_write. Next state is WDATA for a write, RDATA for a read.
- WDATA: DATA_WIDTH cycles of write data, LSB first, bus_out_valid = 1. Then go to DONE.
- RDATA: bus_out_valid = 0. On each cycle with bus_in_valid = 1, shift bus_in into bit position [count], LSB first. Stalls (bus_in_valid = 0) are allowed. After DATA_WIDTH valid bits, go to DONE.
- DONE: one cycle. rsp_valid = 1, m_request = 0, then go to IDLE. rsp_rdata updates only on a successful read.
- Grant loss: m_request stays 1 from REQ through the last data bit. If m_grant goes 0 during ADDR/WDATA/RDATA, stop shifting immediately, go to DONE with rsp_error = 1.
- Latency (write, immediate grant): 1 + ADDR_WIDTH + DATA_WIDTH + 1 cycles from accept to rsp_valid, i.e. 22 at defaults.
- bus_in_valid outside RDATA is ignored.
- cmd_valid outside IDLE is ignored; the command is not queued.
- Back-to-back commands: the earliest next accept is the cycle after DONE.
- Bit counter width: clog2(max(ADDR_WIDTH, DATA_WIDTH)) + 1. Resets to 0 on each phase entry.

Optional Feature:
- Macro: BUS_MASTER_TIMEOUT_EN.
- Defined: a counter in RDATA counts cycles since the last valid bit. On reaching TIMEOUT_CYCLES without completion, go to DONE with rsp_error = 1. The counter resets on every bus_in_valid.
- Undefined: RDATA waits indefinitely. rsp_error is asserted only on grant loss.

Test Plan:
- Write, slave 2'b10, addr 12'hA5C, data 8'h3C, grant one cycle after request -> bus_out sequence is 0,0,1,1,1,0,1,0,0,1,0,1 then 0,0,1,1,1,1,0,0; rsp_valid 22 cycles after accept; rsp_error = 0.
- Read, slave 2'b01, slave returns 8'h96 LSB first with 2-cycle gaps -> rsp_rdata = 8'h96, rsp_error = 0, m_request low in the DONE cycle.
- Grant withheld 10 cycles -> m_request and m_slave_sel steady for all 10 cycles; no bus_out_valid before grant.
- m_grant drops after 5 address bits -> shifting stops, rsp_valid with rsp_error = 1 on the next cycle, cmd_ready = 1 on the following cycle.
- rst asserted during WDATA -> no rsp_valid; all outputs at reset values one cycle later; a new command is accepted afterwards.
- With BUS_MASTER_TIMEOUT_EN, TIMEOUT_CYCLES = 20: read with no bus_in_valid -> rsp_error = 1 exactly 20 cycles after RDATA entry; without the macro, still waiting at cycle 100.
